enc_bind_sched: RTL and testbench

- Controller that sequences NUM_PACKS binder packs, each binding FEATURES_PER_CC level HVs per pass, across one sample of NUM_FEATURES features.
- Per pass it issues a level-memory read and pulses start_encoding with a per-pack enable mask. It then presents the bound HVs to the bundler over a valid/ready handshake.
- Sits between the level-HV memory, the binder packs and the bundler/accumulator in the encoder top.

---
 rtl/enc_sched_pkg.sv | 52 +++++
 rtl/enc_lat_cnt.sv | 27 ++
 rtl/enc_bind_sched.sv | 217 +++++++++++++++++++++
 tb/tb_enc_bind_sched.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_sched_pkg.sv
// Shared types and elaboration helpers for the encoder bind scheduler.
// Pass geometry and the per-pass pack enable mask live here so the top and any
// neighbouring block agree on them.
package enc_sched_pkg;

  localparam int unsigned MAX_PACKS  = 32;
  localparam int unsigned PACK_IDX_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MWAIT = 3'd2,
    S_BIND  = 3'd3,
    S_BWAIT = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } sched_state_e;

  // Features covered by all packs in one pass.
  function automatic int unsigned calc_chunk(input int unsigned num_packs,
                                             input int unsigned feat_per_cc);
    return num_packs * feat_per_cc;
  endfunction

  function automatic int unsigned calc_num_passes(input int unsigned num_features,
                                                  input int unsigned chunk);
    return (num_features + chunk - 1) / chunk;
  endfunction

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int unsigned calc_idx_w(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // A pack is enabled only if its first feature of this pass is in range.
  function automatic logic [MAX_PACKS-1:0] calc_pack_mask(input int unsigned pass,
                                                          input int unsigned num_features,
                                                          input int unsigned feat_per_cc,
                                                          input int unsigned num_packs);
    logic [MAX_PACKS-1:0] mask;
    int unsigned          base;
    mask = '0;
    base = pass * num_packs * feat_per_cc;
    for (int unsigned p = 0; p < MAX_PACKS; p++) begin
      if ((p < num_packs) && ((base + p * feat_per_cc) < num_features)) begin
        mask[PACK_IDX_W'(p)] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/enc_lat_cnt.sv
// Loadable down-counter timing the memory and binder wait states.
// Saturates at zero; a load always wins over the decrement.
module enc_lat_cnt #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/enc_bind_sched.sv
// Sequences the binder packs over one sample: fetch level row, start binding,
// hand the bound HVs to the bundler, repeat per pass, then pulse done.
module enc_bind_sched
  import enc_sched_pkg::*;
#(
  parameter  int unsigned NUM_FEATURES    = 620,
  parameter  int unsigned FEATURES_PER_CC = 5,
  parameter  int unsigned NUM_PACKS       = 2,
  parameter  int unsigned MEM_LAT         = 1,
  parameter  int unsigned BIND_LAT        = 1,
  localparam int unsigned CHUNK           = calc_chunk(NUM_PACKS, FEATURES_PER_CC),
  localparam int unsigned NUM_PASSES      = calc_num_passes(NUM_FEATURES, CHUNK),
  localparam int unsigned ADDR_W          = calc_idx_w(NUM_PASSES),
  localparam int unsigned FB_W            = calc_idx_w(NUM_FEATURES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 lvl_rd_en,
  output logic [ADDR_W-1:0]    lvl_rd_addr,
  output logic [FB_W-1:0]      feat_base,
  output logic                 start_encoding,
  output logic [NUM_PACKS-1:0] pack_en,
  output logic                 bind_valid,
  input  logic                 bind_ready,
  output logic                 bind_last,
  output logic                 done
);

  localparam int unsigned LAT_MAX = (MEM_LAT > BIND_LAT) ? MEM_LAT : BIND_LAT;
  localparam int unsigned CNT_W   = calc_idx_w(LAT_MAX + 1);

  if ((NUM_FEATURES % FEATURES_PER_CC) != 0) begin : g_chk_features
    $error("NUM_FEATURES must be a multiple of FEATURES_PER_CC");
  end
  if ((MEM_LAT < 1) || (BIND_LAT < 1)) begin : g_chk_lat
    $error("MEM_LAT and BIND_LAT must be at least 1");
  end
  if ((NUM_PACKS < 1) || (NUM_PACKS > MAX_PACKS)) begin : g_chk_packs
    $error("NUM_PACKS out of supported range");
  end

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;
  logic [ADDR_W-1:0]    r_pass;
  logic [ADDR_W-1:0]    w_pass_nxt;
  logic                 w_cnt_load;
  logic [CNT_W-1:0]     w_cnt_load_val;
  logic [CNT_W-1:0]     w_cnt;
  logic                 w_last_pass;
  logic                 w_handshake;

  logic                 w_busy_nxt;
  logic                 w_rd_en_nxt;
  logic [ADDR_W-1:0]    w_rd_addr_nxt;
  logic [FB_W-1:0]      w_feat_base_nxt;
  logic                 w_start_enc_nxt;
  logic [NUM_PACKS-1:0] w_pack_en_nxt;
  logic                 w_bind_valid_nxt;
  logic                 w_bind_last_nxt;
  logic                 w_done_nxt;

  enc_lat_cnt #(
    .WIDTH (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .o_cnt      (w_cnt)
  );

  assign w_last_pass = (r_pass == ADDR_W'(NUM_PASSES - 1));
  // bind_valid is registered, so a ready seen while it is low never counts.
  assign w_handshake = (r_state == S_OUT) && bind_valid && bind_ready;

  // Next-state and pass bookkeeping; abort overrides everything but reset.
  always_comb begin
    w_state_nxt    = r_state;
    w_pass_nxt     = r_pass;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_FETCH;
          w_pass_nxt  = '0;
        end
      end
      S_FETCH: begin
        if (MEM_LAT > 1) begin
          w_state_nxt    = S_MWAIT;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = CNT_W'(MEM_LAT - 1);
        end else begin
          w_state_nxt = S_BIND;
        end
      end
      S_MWAIT: begin
        if (w_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_BIND;
        end
      end
      S_BIND: begin
        if (BIND_LAT > 1) begin
          w_state_nxt    = S_BWAIT;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = CNT_W'(BIND_LAT - 1);
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      S_BWAIT: begin
        if (w_cnt <= CNT_W'(1)) begin
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (w_handshake) begin
          if (w_last_pass) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_FETCH;
            w_pass_nxt  = r_pass + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_pass_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pass_nxt  = '0;
      end
    endcase

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_pass_nxt  = '0;
      w_cnt_load  = 1'b0;
    end
  end

  // Output values for the state being entered, so every port is a flop.
  always_comb begin
    w_busy_nxt       = 1'b0;
    w_rd_en_nxt      = 1'b0;
    w_rd_addr_nxt    = '0;
    w_feat_base_nxt  = '0;
    w_start_enc_nxt  = 1'b0;
    w_pack_en_nxt    = '0;
    w_bind_valid_nxt = 1'b0;
    w_bind_last_nxt  = 1'b0;
    w_done_nxt       = 1'b0;

    if (w_state_nxt != S_IDLE) begin
      w_busy_nxt      = 1'b1;
      w_feat_base_nxt = FB_W'(32'(w_pass_nxt) * CHUNK);
    end

    case (w_state_nxt)
      S_FETCH: begin
        w_rd_en_nxt   = 1'b1;
        w_rd_addr_nxt = w_pass_nxt;
      end
      S_BIND: begin
        w_start_enc_nxt = 1'b1;
        w_pack_en_nxt   = NUM_PACKS'(calc_pack_mask(32'(w_pass_nxt), NUM_FEATURES,
                                                    FEATURES_PER_CC, NUM_PACKS));
      end
      S_OUT: begin
        w_bind_valid_nxt = 1'b1;
        w_bind_last_nxt  = (w_pass_nxt == ADDR_W'(NUM_PASSES - 1));
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // State, pass counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pass         <= '0;
      busy           <= 1'b0;
      lvl_rd_en      <= 1'b0;
      lvl_rd_addr    <= '0;
      feat_base      <= '0;
      start_encoding <= 1'b0;
      pack_en        <= '0;
      bind_valid     <= 1'b0;
      bind_last      <= 1'b0;
      done           <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pass         <= w_pass_nxt;
      busy           <= w_busy_nxt;
      lvl_rd_en      <= w_rd_en_nxt;
      lvl_rd_addr    <= w_rd_addr_nxt;
      feat_base      <= w_feat_base_nxt;
      start_encoding <= w_start_enc_nxt;
      pack_en        <= w_pack_en_nxt;
      bind_valid     <= w_bind_valid_nxt;
      bind_last      <= w_bind_last_nxt;
      done           <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_enc_bind_sched.sv
// Bench for enc_bind_sched: default instance (620 features, unit latencies) and a
// small instance (25 features, MEM_LAT=3, BIND_LAT=2) checked against a pass/phase model.
module tb_enc_bind_sched;

  localparam int NI    = 2;
  localparam int FPC   = 5;
  localparam int NPK   = 2;
  localparam int CHUNK = 10;
  localparam int NF_A [NI] = '{620, 25};
  localparam int ML_A [NI] = '{1, 3};
  localparam int BL_A [NI] = '{1, 2};

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] start;
  logic [NI-1:0] abort;
  logic [NI-1:0] ready;

  logic       busy0, rd0, se0, bv0, bl0, done0;
  logic [5:0] addr0;
  logic [9:0] base0;
  logic [1:0] pe0;
  logic       busy1, rd1, se1, bv1, bl1, done1;
  logic [1:0] addr1;
  logic [4:0] base1;
  logic [1:0] pe1;

  int g_busy [NI], g_rd [NI], g_addr [NI], g_base [NI], g_se [NI];
  int g_pe [NI], g_bv [NI], g_bl [NI], g_done [NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  bit m_act  [NI];
  bit m_done [NI];
  int m_pass [NI];
  int m_t    [NI];
  int s_cyc  [NI];

  int n_rd, addr_bad, n_se, pe_bad, n_bv, bl_idx, bl_cnt, se_lat, bv_lat, stall_len;
  int pe_q[$];
  int base_q[$];

  always #5 clk = ~clk;

  enc_bind_sched u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .start          (start[0]),
    .abort          (abort[0]),
    .busy           (busy0),
    .lvl_rd_en      (rd0),
    .lvl_rd_addr    (addr0),
    .feat_base      (base0),
    .start_encoding (se0),
    .pack_en        (pe0),
    .bind_valid     (bv0),
    .bind_ready     (ready[0]),
    .bind_last      (bl0),
    .done           (done0)
  );

  enc_bind_sched #(
    .NUM_FEATURES    (25),
    .FEATURES_PER_CC (5),
    .NUM_PACKS       (2),
    .MEM_LAT         (3),
    .BIND_LAT        (2)
  ) u_dut1 (
    .clk            (clk),
    .rst            (rst),
    .start          (start[1]),
    .abort          (abort[1]),
    .busy           (busy1),
    .lvl_rd_en      (rd1),
    .lvl_rd_addr    (addr1),
    .feat_base      (base1),
    .start_encoding (se1),
    .pack_en        (pe1),
    .bind_valid     (bv1),
    .bind_ready     (ready[1]),
    .bind_last      (bl1),
    .done           (done1)
  );

  always_comb begin
    g_busy[0] = int'(busy0); g_rd[0] = int'(rd0); g_addr[0] = int'(addr0);
    g_base[0] = int'(base0); g_se[0] = int'(se0); g_pe[0] = int'(pe0);
    g_bv[0]   = int'(bv0);   g_bl[0] = int'(bl0); g_done[0] = int'(done0);
    g_busy[1] = int'(busy1); g_rd[1] = int'(rd1); g_addr[1] = int'(addr1);
    g_base[1] = int'(base1); g_se[1] = int'(se1); g_pe[1] = int'(pe1);
    g_bv[1]   = int'(bv1);   g_bl[1] = int'(bl1); g_done[1] = int'(done1);
  end

  function automatic int num_passes(input int i);
    return (NF_A[i] + CHUNK - 1) / CHUNK;
  endfunction

  // Model: a sample is a sequence of passes; within a pass, phase t counts cycles
  // from the fetch (t=0), bind at t=MEM_LAT, output from t=MEM_LAT+BIND_LAT on.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0; m_done[i] <= 1'b0; m_pass[i] <= 0; m_t[i] <= 0;
      end else if (m_done[i]) begin
        m_done[i] <= 1'b0; m_pass[i] <= 0;
      end else if (!m_act[i]) begin
        if (start[i] && !abort[i]) begin
          m_act[i] <= 1'b1; m_pass[i] <= 0; m_t[i] <= 0; s_cyc[i] <= cyc + 1;
        end
      end else if (abort[i]) begin
        m_act[i] <= 1'b0; m_pass[i] <= 0;
      end else if (m_t[i] < ML_A[i] + BL_A[i]) begin
        m_t[i] <= m_t[i] + 1;
      end else if (ready[i]) begin
        if (m_pass[i] == num_passes(i) - 1) begin
          m_act[i] <= 1'b0; m_done[i] <= 1'b1;
        end else begin
          m_pass[i] <= m_pass[i] + 1; m_t[i] <= 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        int e_busy, e_rd, e_addr, e_base, e_se, e_pe, e_bv, e_bl, e_done;
        e_busy = (m_act[i] || m_done[i]) ? 1 : 0;
        e_rd   = (m_act[i] && m_t[i] == 0) ? 1 : 0;
        e_addr = (e_rd == 1) ? m_pass[i] : 0;
        e_base = (e_busy == 1) ? m_pass[i] * CHUNK : 0;
        e_se   = (m_act[i] && m_t[i] == ML_A[i]) ? 1 : 0;
        e_pe   = 0;
        if (e_se == 1) begin
          for (int p = 0; p < NPK; p++) begin
            if (m_pass[i] * CHUNK + p * FPC < NF_A[i]) e_pe = e_pe | (1 << p);
          end
        end
        e_bv   = (m_act[i] && m_t[i] == ML_A[i] + BL_A[i]) ? 1 : 0;
        e_bl   = (e_bv == 1 && m_pass[i] == num_passes(i) - 1) ? 1 : 0;
        e_done = m_done[i] ? 1 : 0;
        n_checks++;
        if (g_busy[i] != e_busy || g_rd[i] != e_rd || g_addr[i] != e_addr ||
            g_base[i] != e_base || g_se[i] != e_se || g_pe[i] != e_pe ||
            g_bv[i] != e_bv || g_bl[i] != e_bl || g_done[i] != e_done) begin
          n_fail++;
          $display("FAIL outputs_inst%0d cyc=%0d got busy=%0d rd=%0d addr=%0d base=%0d se=%0d pe=%0d bv=%0d bl=%0d done=%0d exp busy=%0d rd=%0d addr=%0d base=%0d se=%0d pe=%0d bv=%0d bl=%0d done=%0d",
                   i, cyc, g_busy[i], g_rd[i], g_addr[i], g_base[i], g_se[i], g_pe[i],
                   g_bv[i], g_bl[i], g_done[i], e_busy, e_rd, e_addr, e_base, e_se,
                   e_pe, e_bv, e_bl, e_done);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Run one sample on instance i. mode 1: stall pass 1 for 5 cycles and poke
  // start mid-sample; mode 2: abort together with the pass-2 handshake.
  task automatic run_sample(input int i, input int mode, input int budget, output int done_idx);
    int hold, rd_cyc, se_cyc;
    bit stalled, prev_bv, fin, aborted;
    n_rd = 0; addr_bad = 0; n_se = 0; pe_bad = 0; n_bv = 0; bl_idx = 0; bl_cnt = 0;
    se_lat = -1; bv_lat = -1; stall_len = 0;
    pe_q.delete(); base_q.delete();
    hold = 0; rd_cyc = 0; se_cyc = 0; stalled = 0; prev_bv = 0; fin = 0; aborted = 0;
    done_idx = -1;
    start[i] = 1'b1;
    for (int k = 0; k < budget && !fin; k++) begin
      @(negedge clk); #1;
      start[i] = 1'b0;
      abort[i] = 1'b0;
      if (aborted) begin
        check($sformatf("abort_busy_inst%0d", i), g_busy[i], 0);
        check($sformatf("abort_done_inst%0d", i), g_done[i], 0);
        done_idx = 0;
        fin = 1'b1;
      end else begin
        if (g_rd[i] == 1) begin
          if (g_addr[i] != n_rd) addr_bad++;
          n_rd++;
          rd_cyc = cyc;
          if (mode == 1 && n_rd == 3) start[i] = 1'b1;
        end
        if (g_se[i] == 1) begin
          pe_q.push_back(g_pe[i]);
          if (g_pe[i] != 3) pe_bad++;
          if (n_se == 0) se_lat = cyc - rd_cyc;
          n_se++;
          se_cyc = cyc;
        end
        if (g_bv[i] == 1 && !prev_bv) begin
          base_q.push_back(g_base[i]);
          if (n_bv == 0) bv_lat = cyc - se_cyc;
          n_bv++;
          if (g_bl[i] == 1) begin bl_idx = n_bv; bl_cnt++; end
        end
        if (g_bv[i] == 1 && g_base[i] == CHUNK) stall_len++;
        if (mode == 1) begin
          if (!stalled && g_bv[i] == 1 && g_base[i] == CHUNK) begin
            ready[i] = 1'b0; hold = 5; stalled = 1'b1;
          end else if (hold > 0) begin
            hold--;
            if (hold == 0) ready[i] = 1'b1;
          end
        end
        if (mode == 2 && g_bv[i] == 1 && g_base[i] == 2 * CHUNK) begin
          abort[i] = 1'b1;
          aborted = 1'b1;
        end
        if (g_done[i] == 1) begin
          done_idx = cyc - s_cyc[i] + 1;
          fin = 1'b1;
        end
        prev_bv = (g_bv[i] == 1);
      end
    end
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_inst%0d got=no_done exp=done_within_%0d", i, budget);
    end
    ready[i] = 1'b1;
  endtask

  initial begin
    int idx;
    bit fin;
    rst = 1'b1; start = '0; abort = '0; ready = '1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy0", g_busy[0], 0);
    check("reset_busy1", g_busy[1], 0);
    check("reset_base0", g_base[0], 0);
    rst = 1'b0;

    // start together with abort in IDLE must be ignored
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk); #1;
    start[0] = 1'b0; abort[0] = 1'b0;
    check("idle_start_abort_busy", g_busy[0], 0);

    run_sample(0, 0, 400, idx);
    check("nominal_done_cycle", idx, 187);
    check("nominal_rd_count", n_rd, 62);
    check("nominal_addr_seq_errs", addr_bad, 0);
    check("nominal_se_count", n_se, 62);
    check("nominal_pack_en_errs", pe_bad, 0);
    check("nominal_bv_count", n_bv, 62);
    check("nominal_last_index", bl_idx, 62);
    check("nominal_last_count", bl_cnt, 1);
    @(negedge clk); #1;

    run_sample(0, 1, 400, idx);
    check("backpressure_done_cycle", idx, 192);
    check("backpressure_valid_cycles", stall_len, 6);
    check("backpressure_rd_count", n_rd, 62);
    @(negedge clk); #1;

    run_sample(1, 0, 100, idx);
    check("partial_done_cycle", idx, 19);
    check("partial_passes", base_q.size(), 3);
    check("partial_base0", (base_q.size() > 0) ? base_q[0] : -1, 0);
    check("partial_base1", (base_q.size() > 1) ? base_q[1] : -1, 10);
    check("partial_base2", (base_q.size() > 2) ? base_q[2] : -1, 20);
    check("partial_pe0", (pe_q.size() > 0) ? pe_q[0] : -1, 3);
    check("partial_pe1", (pe_q.size() > 1) ? pe_q[1] : -1, 3);
    check("partial_pe2", (pe_q.size() > 2) ? pe_q[2] : -1, 1);
    check("partial_last_index", bl_idx, 3);
    check("partial_last_count", bl_cnt, 1);
    check("lat_rd_to_se", se_lat, 3);
    check("lat_se_to_bv", bv_lat, 2);
    @(negedge clk); #1;

    run_sample(0, 2, 400, idx);
    check("abort_rd_count", n_rd, 3);
    repeat (3) @(negedge clk);
    #1;
    check("abort_idle_done", g_done[0], 0);
    run_sample(0, 0, 400, idx);
    check("restart_done_cycle", idx, 187);
    check("restart_addr_seq_errs", addr_bad, 0);
    @(negedge clk); #1;

    // reset while instance 1 sits in its binder wait
    start[1] = 1'b1;
    fin = 1'b0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk); #1;
      start[1] = 1'b0;
      if (g_se[1] == 1) fin = 1'b1;
    end
    if (!fin) begin
      n_checks++; n_fail++;
      $display("FAIL timeout_bind_wait got=no_start_encoding exp=start_encoding");
    end
    @(negedge clk); #1;
    check("bwait_busy1", g_busy[1], 1);
    check("bwait_valid1", g_bv[1], 0);
    rst = 1'b1; start[1] = 1'b1; abort[1] = 1'b1;
    @(negedge clk); #1;
    check("midrst_busy1", g_busy[1], 0);
    check("midrst_base1", g_base[1], 0);
    check("midrst_bv1", g_bv[1], 0);
    rst = 1'b0; start[1] = 1'b0; abort[1] = 1'b0;
    @(negedge clk); #1;
    check("post_rst_idle1", g_busy[1], 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
